// File: rtl/dma_bd_pkg.sv
// Shared types and constants for the BD-buffer hit completion path.
// Used by dma_bd_cpld_gen and its descriptor FIFO.
package dma_bd_pkg;

    localparam int RC_DESC_W  = 96;
    localparam int BD_W       = 256;
    localparam int RC_TUSER_W = 75;
    // Queued descriptor record is {tdest, tdata}
    localparam int HDR_W      = RC_DESC_W + 2;

    // RC tuser bit positions
    localparam int TUSER_SOF         = 32;
    localparam int TUSER_EOF_VLD     = 34;
    localparam int TUSER_EOF_PTR_MSB = 37;
    localparam int TUSER_EOF_PTR_LSB = 35;

    // Channel encoding carried on tdest
    localparam logic [1:0] CH0_S2C = 2'd0;
    localparam logic [1:0] CH0_C2S = 2'd1;
    localparam logic [1:0] CH1_S2C = 2'd2;
    localparam logic [1:0] CH1_C2S = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WAIT  = 3'd2,
        ST_BEAT0 = 3'd3,
        ST_BEAT1 = 3'd4
    } cpld_state_t;

    // tuser for a 2-beat, 8-dword completion: byte enables plus sof/eof markers
    function automatic logic [RC_TUSER_W-1:0] rc_tuser(input logic last_beat);
        logic [RC_TUSER_W-1:0] u;
        u = '0;
        if (!last_beat) begin
            u[31:0]      = 32'hFFFF_F000;
            u[TUSER_SOF] = 1'b1;
        end else begin
            u[31:0]                                = 32'h0000_0FFF;
            u[TUSER_EOF_VLD]                       = 1'b1;
            u[TUSER_EOF_PTR_MSB:TUSER_EOF_PTR_LSB] = 3'd2;
        end
        return u;
    endfunction

endpackage

// File: rtl/dma_cpld_hdr_fifo.sv
// Synchronous descriptor FIFO. A push while full is accepted only when a pop
// happens in the same cycle, so occupancy stays at DEPTH without overrun.
module dma_cpld_hdr_fifo
    import dma_bd_pkg::*;
#(
    parameter int WIDTH = HDR_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dma_bd_cpld_gen.sv
// BD-buffer hit responder: queues completion descriptors, reads the matching
// BD entry and emits a 2-beat RC-format CplD toward the BD fetch logic.
// Optional DMA_BD_CPLD_STAT_EN adds per-channel completion and drop counters.
module dma_bd_cpld_gen
    import dma_bd_pkg::*;
#(
    parameter int HDR_FIFO_DEPTH = 8,
    parameter int BUF_RD_LATENCY = 1
) (
    input  logic                    user_clk,
    input  logic                    user_reset_n,
    input  logic [RC_DESC_W-1:0]    s_axis_cpld_header_tdata,
    input  logic [1:0]              s_axis_cpld_header_tdest,
    input  logic                    s_axis_cpld_header_tvalid,
    output logic                    bd_buf_rd_en,
    output logic [1:0]              bd_buf_rd_ch,
    output logic [3:0]              bd_buf_rd_entry,
    input  logic [BD_W-1:0]         bd_buf_rd_data,
    output logic                    m_axis_rc_bd_tvalid,
    input  logic                    m_axis_rc_bd_tready,
    output logic [255:0]            m_axis_rc_bd_tdata,
    output logic [7:0]              m_axis_rc_bd_tkeep,
    output logic                    m_axis_rc_bd_tlast,
    output logic [RC_TUSER_W-1:0]   m_axis_rc_bd_tuser,
    output logic                    hdr_overflow,
    output cpld_state_t             fsm_state
`ifdef DMA_BD_CPLD_STAT_EN
    ,
    output logic [127:0]            cpld_cnt,
    output logic [15:0]             drop_cnt
`endif
);

    // Stream handshake: a beat transfers on a cycle where tvalid and tready
    // are both high; once tvalid rises, it and every payload field hold until
    // that transfer. The header input has no ready, so overflow drops.

    localparam int CNT_W = $clog2(HDR_FIFO_DEPTH) + 1;

    logic [HDR_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    cpld_state_t      state;
    logic [1:0]       wait_cnt;
    logic [95:0]      bd_hi;
    logic             pop;
    logic             drop;
    logic             more_after_pop;

    assign pop  = (state == ST_BEAT1) && m_axis_rc_bd_tready;
    assign drop = s_axis_cpld_header_tvalid && fifo_full && !pop;
    // In BEAT1 the FIFO holds at least one entry (the one being completed)
    assign more_after_pop = (fifo_count != CNT_W'(1)) || s_axis_cpld_header_tvalid;

    dma_cpld_hdr_fifo #(
        .WIDTH (HDR_W),
        .DEPTH (HDR_FIFO_DEPTH)
    ) u_hdr_fifo (
        .clk       (user_clk),
        .rst_n     (user_reset_n),
        .push      (s_axis_cpld_header_tvalid),
        .push_data ({s_axis_cpld_header_tdest, s_axis_cpld_header_tdata}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Read strobe is a decode of the registered state, so it is glitch-free
    assign bd_buf_rd_en    = (state == ST_RD);
    assign bd_buf_rd_ch    = bd_buf_rd_en ? head[HDR_W-1:HDR_W-2] : 2'd0;
    assign bd_buf_rd_entry = bd_buf_rd_en ? head[8:5] : 4'd0;
    assign fsm_state       = state;

    // Completion FSM with registered stream outputs
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state               <= ST_IDLE;
            wait_cnt            <= '0;
            bd_hi               <= '0;
            m_axis_rc_bd_tvalid <= 1'b0;
            m_axis_rc_bd_tdata  <= '0;
            m_axis_rc_bd_tkeep  <= '0;
            m_axis_rc_bd_tlast  <= 1'b0;
            m_axis_rc_bd_tuser  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) state <= ST_RD;
                end
                ST_RD: begin
                    wait_cnt <= 2'(BUF_RD_LATENCY - 1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        m_axis_rc_bd_tvalid <= 1'b1;
                        m_axis_rc_bd_tdata  <= {bd_buf_rd_data[159:0], head[RC_DESC_W-1:0]};
                        m_axis_rc_bd_tkeep  <= 8'hFF;
                        m_axis_rc_bd_tlast  <= 1'b0;
                        m_axis_rc_bd_tuser  <= rc_tuser(1'b0);
                        bd_hi               <= bd_buf_rd_data[255:160];
                        state               <= ST_BEAT0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_BEAT0: begin
                    if (m_axis_rc_bd_tready) begin
                        m_axis_rc_bd_tdata <= {160'd0, bd_hi};
                        m_axis_rc_bd_tkeep <= 8'h07;
                        m_axis_rc_bd_tlast <= 1'b1;
                        m_axis_rc_bd_tuser <= rc_tuser(1'b1);
                        state              <= ST_BEAT1;
                    end
                end
                ST_BEAT1: begin
                    if (m_axis_rc_bd_tready) begin
                        m_axis_rc_bd_tvalid <= 1'b0;
                        m_axis_rc_bd_tdata  <= '0;
                        m_axis_rc_bd_tkeep  <= '0;
                        m_axis_rc_bd_tlast  <= 1'b0;
                        m_axis_rc_bd_tuser  <= '0;
                        state               <= more_after_pop ? ST_RD : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky flag for a descriptor lost to a full FIFO
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) hdr_overflow <= 1'b0;
        else if (drop)     hdr_overflow <= 1'b1;
    end

`ifdef DMA_BD_CPLD_STAT_EN
    // Per-channel completion counters (wrapping) and saturating drop counter
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            cpld_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (pop) begin
                case (head[HDR_W-1:HDR_W-2])
                    CH0_S2C: cpld_cnt[31:0]   <= cpld_cnt[31:0]   + 32'd1;
                    CH0_C2S: cpld_cnt[63:32]  <= cpld_cnt[63:32]  + 32'd1;
                    CH1_S2C: cpld_cnt[95:64]  <= cpld_cnt[95:64]  + 32'd1;
                    CH1_C2S: cpld_cnt[127:96] <= cpld_cnt[127:96] + 32'd1;
                    default: cpld_cnt <= cpld_cnt;
                endcase
            end
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/dma_bd_cpld_gen.md
Name: dma_bd_cpld_gen

Overview:
- Responder end of the BD-buffer hit path. A BD read request that hits the BD buffer produces a 96-bit completion descriptor on the cpld-header stream; this block queues each descriptor.
- For each queued descriptor it reads the matching 256-bit BD entry from the per-channel BD buffer.
- It emits a 2-beat CplD on the 256-bit RC-format AXI-Stream toward the DMA engine's BD fetch logic, so the engine sees a normal completion without a PCIe round trip.

Parameters:
- HDR_FIFO_DEPTH, 8, descriptor FIFO entries (power of 2, 2..32).
- BUF_RD_LATENCY, 1, cycles from bd_buf_rd_en to valid bd_buf_rd_data (1..4).

Ports:
- user_clk  in  1  clock.
- user_reset_n  in  1  asynchronous active-low reset.
- s_axis_cpld_header_tdata  in  96  RC descriptor: [11:0] lower address, [28:16] byte count, [42:32] dword count, [95:64] tag/completer fields.
- s_axis_cpld_header_tdest  in  2  channel: 0=ch0_s2c, 1=ch0_c2s, 2=ch1_s2c, 3=ch1_c2s.
- s_axis_cpld_header_tvalid  in  1  push strobe; the stream has no tready.
- bd_buf_rd_en  out  1  BD buffer read strobe, one cycle.
- bd_buf_rd_ch  out  2  channel select.
- bd_buf_rd_entry  out  4  entry index (descriptor bits [8:5]).
- bd_buf_rd_data  in  256  BD entry, valid BUF_RD_LATENCY cycles after rd_en.
- m_axis_rc_bd_tvalid  out  1  completion beat valid.
- m_axis_rc_bd_tready  in  1  downstream ready.
- m_axis_rc_bd_tdata  out  256  completion beat.
- m_axis_rc_bd_tkeep  out  8  dword keep.
- m_axis_rc_bd_tlast  out  1  last beat.
- m_axis_rc_bd_tuser  out  75  RC sideband.
- hdr_overflow  out  1  sticky: a descriptor arrived while the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; FSM in IDLE.
  - All outputs 0: tvalid, tdata, tkeep, tlast, tuser, rd_en, rd_ch, rd_entry, hdr_overflow.
  - A reset asserted mid-completion discards that completion and any queued descriptors.
- FIFO:
  - Pushes {tdest, tdata} when tvalid is high and the FIFO is not full.
  - Push while full: descriptor dropped, hdr_overflow set until reset.
  - Pop happens on acceptance of the last beat. A push and pop in the same cycle while full are both accepted; occupancy is unchanged and no overflow is flagged.
- FSM states IDLE, RD, WAIT, BEAT0, BEAT1:
  - IDLE: if the FIFO is not empty, go to RD.
  - RD: one cycle; rd_en=1, rd_ch and rd_entry taken from the FIFO head; load wait counter with BUF_RD_LATENCY-1; go to WAIT.
  - WAIT: decrement the counter; when it reaches 0, capture bd_buf_rd_data in that cycle's edge and go to BEAT0.
  - BEAT0: tvalid=1, tdata={bd[159:0], desc[95:0]}, tkeep=8'hFF, tlast=0; on tready, go to BEAT1.
  - BEAT1: tvalid=1, tdata={160'b0, bd[255:160]}, tkeep=8'h07, tlast=1; on tready, pop the FIFO and go to RD if the FIFO is still not empty, else IDLE.
- Latency: descriptor push to BEAT0 tvalid = BUF_RD_LATENCY+3 cycles with the FIFO empty and the FSM idle.
- Output rules:
  - tdata, tkeep, tlast and tuser stay stable while tvalid=1 and tready=0.
  - tvalid never drops before acceptance.
  - Outputs are driven to 0 in IDLE, RD and WAIT.
- tuser per beat (all other bits 0):
  - BEAT0: [31:0]=32'hFFFF_F000, [32]=1 (sof).
  - BEAT1: [31:0]=32'h0000_0FFF, [34]=1 (eof valid), [37:35]=3'd2.
- Descriptor content: passed through unmodified. The block does not check the byte/dword counts; hits are always single-BD (32 bytes, 8 dwords).
- Ordering: completions leave strictly in descriptor arrival order across all channels.

Optional Feature:
- Macro DMA_BD_CPLD_STAT_EN.
- When defined:
  - Adds output port cpld_cnt (128 bits): four 32-bit per-channel counters, ch0_s2c in [31:0].
  - A counter increments on BEAT1 acceptance for its channel and wraps at 2^32.
  - Adds output port drop_cnt (16 bits): counts overflow drops, saturating at 16'hFFFF.
  - All counters reset to 0.
- When undefined: neither port exists and no counter logic is built.

Decomposition:
- Package dma_bd_pkg:
  - Constants RC_DESC_W=96, BD_W=256, RC_TUSER_W=75.
  - tuser bit positions: SOF=32, EOF_VLD=34, EOF_PTR msb=37, lsb=35.
  - Channel encoding constants.
  - FSM state enum.
- Sub-module dma_cpld_hdr_fifo: synchronous FIFO, width 98, depth HDR_FIFO_DEPTH, with full/empty/push/pop and simultaneous push-pop-when-full handling.

Test Plan:
- Single hit, BUF_RD_LATENCY=1, tready=1, descriptor tdest=2, addr 12'h1A0: rd_entry=4'hD, rd_ch=2; BEAT0 at push+4 cycles with tkeep=FF and tuser[32]=1; BEAT1 tkeep=07, tlast=1, tuser[37:34]=4'b0101.
- Backpressure: hold tready=0 for 5 cycles in BEAT0, then 3 cycles in BEAT1 -> tdata, tuser and tkeep held constant; exactly 2 beats transferred.
- Back-to-back 8 descriptors, channels 0..3 repeated, DEPTH=8, tready toggling 50% -> 8 completions in order with correct BD data; hdr_overflow=0.
- Overflow: push 9 descriptors while tready=0 -> hdr_overflow=1, ninth dropped; with STAT_EN defined, drop_cnt=1.
- Push on the same cycle as the BEAT1 pop with the FIFO full -> accepted, no overflow, FSM goes BEAT1->RD.
- Async reset asserted during BEAT0 -> tvalid goes 0 immediately; after release, the FIFO is empty and no stale beat appears.
